// File: rtl/xif_copro_issue_initiator.sv
// Core-side initiator for the XIF issue/commit/result handshake.
// Holds one candidate instruction, offers it on the issue channel, reports the
// coprocessor decision back to the core, commits or kills it, and limits the
// number of accepted writeback transactions awaiting a result.
//
// state  | meaning
// IDLE   | waiting for the core to offer an instruction (throttled when full)
// ISSUE  | request held on the issue channel until the coprocessor takes it
// COMMIT | single cycle emitting the commit/kill strobe for the latched id
module xif_copro_issue_initiator #(
  parameter int XLEN            = 32,
  parameter int X_NUM_RS        = 2,
  parameter int X_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [X_NUM_RS*XLEN-1:0]   rs_i,
  input  logic [X_NUM_RS-1:0]        rs_valid_i,
  input  logic                       kill_i,
  output logic                       dec_valid_o,
  output logic                       dec_accept_o,
  output logic                       dec_writeback_o,
  output logic                       dec_loadstore_o,
  output logic [X_ID_WIDTH-1:0]      dec_id_o,
  output logic                       x_issue_valid_o,
  input  logic                       x_issue_ready_i,
  output logic [31:0]                x_issue_instr_o,
  output logic [X_ID_WIDTH-1:0]      x_issue_id_o,
  output logic [X_NUM_RS*XLEN-1:0]   x_issue_rs_o,
  output logic [X_NUM_RS-1:0]        x_issue_rs_valid_o,
  input  logic                       x_issue_resp_accept_i,
  input  logic                       x_issue_resp_writeback_i,
  input  logic                       x_issue_resp_loadstore_i,
  output logic                       x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0]      x_commit_id_o,
  output logic                       x_commit_kill_o,
  input  logic                       x_result_valid_i,
  output logic                       x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]      x_result_id_i,
  output logic [CW-1:0]              outstanding_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_e;

  localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTSTANDING);

  state_e                     state_q;
  logic [31:0]                instr_q;
  logic [X_NUM_RS*XLEN-1:0]   rs_q;
  logic [X_NUM_RS-1:0]        rs_valid_q;
  logic [X_ID_WIDTH-1:0]      id_q;
  logic [X_ID_WIDTH-1:0]      next_id_q;
  logic                       kill_pend_q;
  logic                       acc_q, wb_q, ls_q;
  logic                       dec_valid_q;
  logic [CW-1:0]              out_q, out_d;
  logic                       commit_kill, wb_commit, res_hs;

  // Result ids are not tracked; retire order is the coprocessor's business.
  logic unused_result_id;
  assign unused_result_id = ^x_result_id_i;

  // Commit qualification and next in-flight count (commit and retire may coincide).
  always_comb begin
    commit_kill = kill_pend_q | kill_i | ~acc_q;
    wb_commit   = (state_q == COMMIT) & ~commit_kill & wb_q;
    res_hs      = x_result_valid_i & (out_q != '0);
    out_d       = out_q;
    if (wb_commit && !res_hs)      out_d = out_q + CW'(1);
    else if (!wb_commit && res_hs) out_d = out_q - CW'(1);
  end

  // Issue/commit sequencing with latched payload and registered decision pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      rs_q        <= '0;
      rs_valid_q  <= '0;
      id_q        <= '0;
      next_id_q   <= '0;
      kill_pend_q <= 1'b0;
      acc_q       <= 1'b0;
      wb_q        <= 1'b0;
      ls_q        <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      dec_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i && instr_ready_o) begin
            instr_q     <= instr_i;
            rs_q        <= rs_i;
            rs_valid_q  <= rs_valid_i;
            id_q        <= next_id_q;
            kill_pend_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (kill_i) kill_pend_q <= 1'b1;
          if (x_issue_ready_i) begin
            acc_q       <= x_issue_resp_accept_i;
            wb_q        <= x_issue_resp_accept_i & x_issue_resp_writeback_i;
            ls_q        <= x_issue_resp_accept_i & x_issue_resp_loadstore_i;
            dec_valid_q <= 1'b1;
            state_q     <= COMMIT;
          end
        end
        COMMIT: begin
          if (!commit_kill) next_id_q <= next_id_q + X_ID_WIDTH'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outstanding writeback counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_q <= '0;
    else         out_q <= out_d;
  end

  assign instr_ready_o      = (state_q == IDLE) && (out_q < MaxCnt);
  assign x_issue_valid_o    = (state_q == ISSUE);
  assign x_issue_instr_o    = instr_q;
  assign x_issue_id_o       = id_q;
  assign x_issue_rs_o       = rs_q;
  assign x_issue_rs_valid_o = rs_valid_q;
  assign dec_valid_o        = dec_valid_q;
  assign dec_accept_o       = acc_q;
  assign dec_writeback_o    = wb_q;
  assign dec_loadstore_o    = ls_q;
  assign dec_id_o           = id_q;
  assign x_commit_valid_o   = (state_q == COMMIT);
  assign x_commit_id_o      = id_q;
  assign x_commit_kill_o    = (state_q == COMMIT) & commit_kill;
  assign x_result_ready_o   = (out_q != '0);
  assign outstanding_o      = out_q;

endmodule

// File: tb/tb_xif_copro_issue_initiator.sv
// Bench for xif_copro_issue_initiator: directed scenarios plus randomized
// transactions checked against a transaction-level model (next id, count).
module tb_xif_copro_issue_initiator;
  localparam int XLEN = 32, NRS = 2, IDW = 4, MAXO = 4;
  localparam int CW = $clog2(MAXO + 1);

  logic clk = 0, rst_n = 0;
  logic instr_valid = 0, kill = 0, issue_ready = 0;
  logic resp_acc = 0, resp_wb = 0, resp_ls = 0, res_valid = 0;
  logic [31:0] instr = 0;
  logic [NRS*XLEN-1:0] rs = 0;
  logic [NRS-1:0] rsv = 0;
  logic [IDW-1:0] res_id = 0;
  logic instr_ready, dec_valid, dec_acc, dec_wb, dec_ls, issue_valid;
  logic commit_valid, commit_kill, res_ready;
  logic [IDW-1:0] dec_id, issue_id, commit_id;
  logic [31:0] issue_instr;
  logic [NRS*XLEN-1:0] issue_rs;
  logic [NRS-1:0] issue_rsv;
  logic [CW-1:0] outstanding;

  xif_copro_issue_initiator #(.XLEN(XLEN), .X_NUM_RS(NRS), .X_ID_WIDTH(IDW),
    .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_i(instr), .rs_i(rs), .rs_valid_i(rsv), .kill_i(kill),
    .dec_valid_o(dec_valid), .dec_accept_o(dec_acc), .dec_writeback_o(dec_wb),
    .dec_loadstore_o(dec_ls), .dec_id_o(dec_id),
    .x_issue_valid_o(issue_valid), .x_issue_ready_i(issue_ready),
    .x_issue_instr_o(issue_instr), .x_issue_id_o(issue_id), .x_issue_rs_o(issue_rs),
    .x_issue_rs_valid_o(issue_rsv), .x_issue_resp_accept_i(resp_acc),
    .x_issue_resp_writeback_i(resp_wb), .x_issue_resp_loadstore_i(resp_ls),
    .x_commit_valid_o(commit_valid), .x_commit_id_o(commit_id), .x_commit_kill_o(commit_kill),
    .x_result_valid_i(res_valid), .x_result_ready_o(res_ready), .x_result_id_i(res_id),
    .outstanding_o(outstanding));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int exp_id = 0, exp_out = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Idle cycle with an optional result offer; retire happens only if count > 0.
  task automatic result_cycle(input bit offer);
    @(negedge clk);
    instr_valid = 0; kill = 0; issue_ready = 0;
    res_valid = offer; res_id = IDW'($urandom);
    #1;
    chk("res_ready", res_ready, exp_out != 0);
    chk("idle_ready", instr_ready, exp_out < MAXO);
    chk("idle_out", outstanding, exp_out);
    if (offer && exp_out > 0) exp_out--;
    @(negedge clk);
    res_valid = 0;
    #1;
    chk("post_res_out", outstanding, exp_out);
    chk("post_res_ready", instr_ready, exp_out < MAXO);
  endtask

  // One full instruction: offer, hold for dly stall cycles, commit, settle.
  task automatic do_instr(input logic [31:0] ins, input logic [63:0] ops, input logic [1:0] ov,
                          input bit acc, input bit wb, input bit ls, input int dly,
                          input int kill_at, input bit kill_c, input bit res_same);
    bit killed;
    int old_out;
    killed = kill_c || (kill_at >= 0 && kill_at <= dly);
    @(negedge clk);
    instr_valid = 1; instr = ins; rs = ops; rsv = ov; kill = 0; res_valid = 0;
    #1;
    chk("instr_ready", instr_ready, 1);
    chk("issue_idle", issue_valid, 0);
    for (int d = 0; d <= dly; d++) begin
      @(negedge clk);
      instr_valid = 0; instr = $urandom; rs = {$urandom, $urandom}; rsv = 2'($urandom);
      issue_ready = (d == dly); kill = (d == kill_at);
      resp_acc = (d == dly) ? acc : 1'($urandom);
      resp_wb = (d == dly) ? wb : 1'($urandom);
      resp_ls = (d == dly) ? ls : 1'($urandom);
      #1;
      chk("issue_valid", issue_valid, 1);
      chk("issue_instr", issue_instr, ins);
      chk("issue_rs", issue_rs, ops);
      chk("issue_rsv", issue_rsv, ov);
      chk("issue_id", issue_id, exp_id);
      chk("busy_ready", instr_ready, 0);
      chk("early_dec", dec_valid, 0);
    end
    @(negedge clk);
    issue_ready = 0; kill = kill_c; res_valid = res_same;
    resp_acc = 1'($urandom); resp_wb = 1'($urandom); resp_ls = 1'($urandom);
    #1;
    old_out = exp_out;
    chk("dec_valid", dec_valid, 1);
    chk("dec_accept", dec_acc, acc);
    chk("dec_wb", dec_wb, acc & wb);
    chk("dec_ls", dec_ls, acc & ls);
    chk("dec_id", dec_id, exp_id);
    chk("commit_valid", commit_valid, 1);
    chk("commit_id", commit_id, exp_id);
    chk("commit_kill", commit_kill, killed | !acc);
    chk("issue_dropped", issue_valid, 0);
    chk("commit_res_ready", res_ready, old_out != 0);
    if (acc && !killed) begin
      exp_id = (exp_id + 1) % (1 << IDW);
      if (wb) exp_out++;
    end
    if (res_same && old_out > 0) exp_out--;
    @(negedge clk);
    kill = 0; res_valid = 0;
    #1;
    chk("outstanding", outstanding, exp_out);
    chk("dec_pulse", dec_valid, 0);
    chk("commit_pulse", commit_valid, 0);
    chk("ready_after", instr_ready, exp_out < MAXO);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_issue_id", issue_id, 0);
    @(negedge clk); rst_n = 1;
    #1;
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_res_ready", res_ready, 0);

    // Basic accepted writeback, then stall, reject, and kill cases.
    do_instr(32'h0200702B, 64'h1111_2222_3333_4444, 2'b11, 1, 1, 0, 0, -1, 0, 0);
    do_instr(32'hDEADBEEF, 64'hA5A5_0000_5A5A_FFFF, 2'b01, 1, 0, 1, 5, -1, 0, 0);
    do_instr(32'h12345678, 64'h0, 2'b10, 0, 1, 1, 1, -1, 0, 0);
    do_instr(32'h0BADF00D, 64'h7, 2'b11, 1, 1, 0, 2, 1, 0, 0);
    do_instr(32'h0BADF00E, 64'h8, 2'b11, 1, 1, 0, 0, -1, 1, 0);

    // Fill to the limit; ready must stay low, including on the retire cycle.
    while (exp_out < MAXO) do_instr($urandom, {$urandom, $urandom}, 2'b11, 1, 1, 0, 0, -1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); instr_valid = 1; #1;
      chk("full_ready", instr_ready, 0);
      chk("full_no_issue", issue_valid, 0);
    end
    @(negedge clk); instr_valid = 0;
    result_cycle(1);
    chk("out_after_retire", outstanding, MAXO - 1);
    while (exp_out > 0) result_cycle(1);
    result_cycle(1);

    // Id wrap with non-writeback accepts, then retire in the same cycle as a commit.
    for (int i = 0; i < 17; i++) do_instr($urandom, {$urandom, $urandom}, 2'($urandom), 1, 0, 0, 0, -1, 0, 0);
    do_instr($urandom, 64'h1, 2'b01, 1, 1, 0, 0, -1, 0, 0);
    do_instr($urandom, 64'h2, 2'b01, 1, 1, 0, 0, -1, 0, 1);
    chk("same_cycle_count", outstanding, 1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if (exp_out == MAXO || $urandom_range(0, 3) == 0) result_cycle($urandom_range(0, 1) == 1);
      if (exp_out == MAXO) result_cycle(1);
      do_instr($urandom, {$urandom, $urandom}, 2'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom), $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
               $urandom_range(0, 7) == 0, 1'($urandom));
    end

    // Reset in the middle of an issue: no commit, everything cleared.
    @(negedge clk);
    instr_valid = 1; instr = 32'hCAFE0001; rs = 64'h9; rsv = 2'b11;
    @(negedge clk);
    instr_valid = 0; issue_ready = 0;
    #1;
    chk("pre_rst_issue", issue_valid, 1);
    rst_n = 0;
    #1;
    chk("midrst_issue", issue_valid, 0);
    chk("midrst_commit", commit_valid, 0);
    chk("midrst_out", outstanding, 0);
    chk("midrst_id", issue_id, 0);
    exp_id = 0; exp_out = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    chk("midrst_no_commit", commit_valid, 0);
    do_instr(32'h0200702B, 64'h5, 2'b11, 1, 1, 0, 0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
